// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - execute-unit and divider handshake bundle for div_ctrl
interface div_ctrl_if;
  logic        req_valid_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_addr_i;
  logic        annul_i;
  logic        stall_o;
  logic        wb_valid_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        div_start_o;
  logic        div_signed_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic        div_annul_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;

  modport slave (
    input  req_valid_i, op_i, rs1_i, rs2_i, rd_addr_i, annul_i, div_result_i, div_ready_i,
    output stall_o, wb_valid_o, wb_addr_o, wb_data_o,
           div_start_o, div_signed_o, div_dividend_o, div_divisor_o, div_annul_o
  );

  modport master (
    output req_valid_i, op_i, rs1_i, rs2_i, rd_addr_i, annul_i, div_result_i, div_ready_i,
    input  stall_o, wb_valid_o, wb_addr_o, wb_data_o,
           div_start_o, div_signed_o, div_dividend_o, div_divisor_o, div_annul_o
  );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - DIV/DIVU/REM/REMU sequencer for the iterative divider
// Optional last-result reuse is enabled by defining DIV_RESULT_REUSE_EN.
module div_ctrl (
  input logic       clk_i,
  input logic       n_rst_i,
  div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] rs1_q, rs2_q;
  logic [4:0]  rd_q;
  logic        wb_valid_q;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        load_wb;
  logic        accept;
  logic        reuse_hit;
  logic [63:0] reuse_res;

  assign accept = (state_q == IDLE) && bus.req_valid_i && !bus.annul_i;

`ifdef DIV_RESULT_REUSE_EN
  logic        reuse_valid_q;
  logic [63:0] reuse_res_q;
  logic [31:0] reuse_rs1_q, reuse_rs2_q;
  logic        reuse_signed_q;

  assign reuse_hit = reuse_valid_q && (reuse_rs1_q == bus.rs1_i) &&
                     (reuse_rs2_q == bus.rs2_i) && (reuse_signed_q == !bus.op_i[0]);
  assign reuse_res = reuse_res_q;

  // Only a completed division refreshes the entry; flushes leave it untouched.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      reuse_valid_q  <= 1'b0;
      reuse_res_q    <= '0;
      reuse_rs1_q    <= '0;
      reuse_rs2_q    <= '0;
      reuse_signed_q <= 1'b0;
    end else if (state_q == BUSY && state_d == DONE) begin
      reuse_valid_q  <= 1'b1;
      reuse_res_q    <= bus.div_result_i;
      reuse_rs1_q    <= rs1_q;
      reuse_rs2_q    <= rs2_q;
      reuse_signed_q <= !op_q[0];
    end
  end
`else
  assign reuse_hit = 1'b0;
  assign reuse_res = '0;
`endif

  always_comb begin
    state_d   = state_q;
    load_wb   = 1'b0;
    wb_addr_d = rd_q;
    wb_data_d = wb_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.rs2_i == '0) begin
            state_d   = DONE;
            load_wb   = 1'b1;
            wb_addr_d = bus.rd_addr_i;
            wb_data_d = bus.op_i[1] ? bus.rs1_i : 32'hFFFF_FFFF;
          end else if (reuse_hit) begin
            state_d   = DONE;
            load_wb   = 1'b1;
            wb_addr_d = bus.rd_addr_i;
            wb_data_d = bus.op_i[1] ? reuse_res[63:32] : reuse_res[31:0];
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // A flush wins over a result arriving in the same cycle.
        if (bus.annul_i) begin
          state_d = FLUSH;
        end else if (bus.div_ready_i) begin
          state_d   = DONE;
          load_wb   = 1'b1;
          wb_data_d = op_q[1] ? bus.div_result_i[63:32] : bus.div_result_i[31:0];
        end
      end
      DONE:    state_d = IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= load_wb;
      if (accept) begin
        op_q  <= bus.op_i;
        rs1_q <= bus.rs1_i;
        rs2_q <= bus.rs2_i;
        rd_q  <= bus.rd_addr_i;
      end
      if (load_wb) begin
        wb_addr_q <= wb_addr_d;
        wb_data_q <= wb_data_d;
      end
    end
  end

  assign bus.stall_o        = accept || (state_q == BUSY) || (state_q == FLUSH);
  assign bus.wb_valid_o     = wb_valid_q;
  assign bus.wb_addr_o      = wb_addr_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.div_start_o    = (state_q == BUSY);
  assign bus.div_signed_o   = (state_q == BUSY) && !op_q[0];
  assign bus.div_dividend_o = rs1_q;
  assign bus.div_divisor_o  = rs2_q;
  assign bus.div_annul_o    = (state_q == BUSY) && bus.annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard bench for div_ctrl with a 35-cycle divider model
module tb_div_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  div_ctrl_if bus ();

  div_ctrl dut (.clk_i(clk), .n_rst_i(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          when;
  } exp_t;
  exp_t exp_q[$];

  logic        ent_valid = 1'b0;
  logic [31:0] ent_a, ent_b;
  logic        ent_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic [63:0] long_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] qr;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    qr = long_div(!op[0], a, b);
    return op[1] ? qr[63:32] : qr[31:0];
  endfunction

  task automatic predict(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output int lat);
    d = ref_result(op, a, b);
    lat = 37;
    if (b == 0) lat = 1;
`ifdef DIV_RESULT_REUSE_EN
    else if (ent_valid && ent_a == a && ent_b == b && ent_s == !op[0]) lat = 1;
`endif
    if (lat == 37) begin
      ent_valid = 1'b1; ent_a = a; ent_b = b; ent_s = !op[0];
    end
  endtask

  // Divider stand-in: level-held start, result after 35 start-high cycles.
  int dcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= 0;
      bus.div_ready_i  <= 1'b0;
      bus.div_result_i <= '0;
    end else if (!bus.div_start_o || bus.div_annul_o) begin
      dcnt <= 0;
      bus.div_ready_i <= 1'b0;
    end else begin
      dcnt <= dcnt + 1;
      if (dcnt == 34) begin
        bus.div_ready_i  <= 1'b1;
        bus.div_result_i <= long_div(bus.div_signed_o, bus.div_dividend_o, bus.div_divisor_o);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.wb_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", {27'b0, bus.wb_addr_o, bus.wb_data_o}, 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_addr", bus.wb_addr_o, e.addr);
        chk("wb_data", bus.wb_data_o, e.data);
        chk("wb_cycle", cyc, e.when);
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.req_valid_i = 1'b1;
    bus.op_i = op; bus.rs1_i = a; bus.rs2_i = b; bus.rd_addr_i = rd;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] d;
    int lat, nst, nsa;
    predict(op, a, b, d, lat);
    @(posedge clk); #1;
    drive(op, a, b, rd);
    exp_q.push_back('{rd, d, cyc + lat});
    nst = 0; nsa = 0;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin @(posedge clk); #1; bus.req_valid_i = 1'b0; end
      #1;
      nst += int'(bus.stall_o);
      nsa += int'(bus.div_start_o);
    end
    chk("stall_cycles", nst, lat);
    chk("start_cycles", nsa, (lat > 1) ? lat - 1 : 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int lat, c0, d_cyc;
    bit seen;
    bus.req_valid_i = 0; bus.op_i = 0; bus.rs1_i = 0; bus.rs2_i = 0;
    bus.rd_addr_i = 0; bus.annul_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_outputs", {bus.wb_valid_o, bus.wb_addr_o, bus.wb_data_o, bus.div_start_o,
                        bus.div_signed_o, bus.div_annul_o}, 0);
    chk("rst_operands", {bus.div_dividend_o, bus.div_divisor_o}, 0);
    rst_n = 1'b1;

    do_req(2'b01, 32'd100, 32'd7, 5'd5);
    do_req(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd6);
    do_req(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd7);
    do_req(2'b00, 32'd1234, 32'd0, 5'd8);
    do_req(2'b11, 32'd1234, 32'd0, 5'd9);
    do_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    do_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);

    // Flush in the middle of a division.
    @(posedge clk); #1;
    drive(2'b01, 32'd5000, 32'd13, 5'd12);
    @(posedge clk); #1; bus.req_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1; bus.annul_i = 1'b1;
    #1;
    chk("annul_pass", bus.div_annul_o, 1);
    chk("annul_stall", bus.stall_o, 1);
    @(posedge clk); #1; bus.annul_i = 1'b0;
    #1;
    chk("flush_state", {bus.stall_o, bus.div_start_o}, 2'b10);
    @(posedge clk); #2;
    chk("flush_idle", {bus.stall_o, bus.div_start_o}, 2'b00);
    do_req(2'b01, 32'd9, 32'd3, 5'd13);

    // Back-to-back with req held high across DONE.
    predict(2'b01, 32'd77777, 32'd11, d, lat);
    @(posedge clk); #1;
    drive(2'b01, 32'd77777, 32'd11, 5'd14);
    exp_q.push_back('{5'd14, d, cyc + lat});
    seen = 0; d_cyc = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(posedge clk); #2;
      if (bus.wb_valid_o) begin seen = 1; d_cyc = cyc; end
    end
    chk("b2b_first_done", seen, 1);
    chk("b2b_done_start", {bus.div_start_o, bus.stall_o}, 0);
    predict(2'b10, 32'hFFFF_0000, 32'd300, d, lat);
    @(posedge clk); #1;
    drive(2'b10, 32'hFFFF_0000, 32'd300, 5'd15);
    c0 = cyc;
    exp_q.push_back('{5'd15, d, c0 + lat});
    #1;
    chk("b2b_gap_start", bus.div_start_o, 0);
    chk("b2b_accept_cycle", c0, d_cyc + 1);
    @(posedge clk); #1; bus.req_valid_i = 1'b0;
    repeat (lat + 1) @(posedge clk);

    for (int i = 0; i < 18; i++)
      do_req(2'($urandom_range(0, 3)), pick(), pick(), 5'($urandom_range(0, 31)));

    // Reset in the middle of a division.
    @(posedge clk); #1;
    drive(2'b00, 32'd999, 32'd4, 5'd20);
    @(posedge clk); #1; bus.req_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {bus.stall_o, bus.wb_valid_o, bus.div_start_o, bus.div_signed_o,
                           bus.div_annul_o}, 0);
    chk("midrst_operands", {bus.div_dividend_o, bus.div_divisor_o}, 0);
    ent_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    do_req(2'b00, 32'd999, 32'd4, 5'd21);

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller between the execute unit and the iterative 32-bit divider. Accepts one DIV/DIVU/REM/REMU request at a time and stalls the pipeline while it runs. Drives the divider's level-held start/annul protocol, selects quotient or remainder and issues a one-cycle writeback. Handles divide-by-zero in one cycle without occupying the divider.

## Interface
- No parameters.
- clk_i  input  1  clock
- n_rst_i  input  1  reset, asynchronous, active-low
- req_valid_i  input  1  divide request from the execute unit
- op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_i  input  32  dividend
- rs2_i  input  32  divisor
- rd_addr_i  input  5  destination register
- annul_i  input  1  exception/interrupt flush
- stall_o  output  1  hold the pipeline
- wb_valid_o  output  1  writeback strobe, one cycle
- wb_addr_o  output  5  writeback register
- wb_data_o  output  32  writeback data
- div_start_o  output  1  divider start, held for the whole division
- div_signed_o  output  1  divider signed mode
- div_dividend_o  output  32  divider dividend
- div_divisor_o  output  32  divider divisor
- div_annul_o  output  1  divider annul
- div_result_i  input  64  divider result: [31:0] quotient, [63:32] remainder
- div_ready_i  input  1  divider result valid

## Operation
- States: IDLE, BUSY, DONE, FLUSH. Reset enters IDLE.
- Outputs at reset: all outputs 0.
- Registered on reset: wb_* and the operand, op and rd registers all clear to 0.
- IDLE, req_valid_i=1, annul_i=0: capture op, rs1, rs2 and rd.
  - rs2==0: no divider use. Go to DONE with data = 0xFFFFFFFF for DIV/DIVU, or rs1 for REM/REMU.
  - Otherwise: go to BUSY.
- IDLE with annul_i=1: drop the request; stay in IDLE.
- BUSY: div_start_o=1.
  - Drive div_dividend_o and div_divisor_o from the captured rs1 and rs2.
  - Drive div_signed_o = ~op[0].
- BUSY, div_ready_i=1, annul_i=0: register data, then go to DONE.
  - Data is div_result_i[63:32] when op[1]=1, else div_result_i[31:0].
- BUSY, annul_i=1: go to FLUSH and discard the result. This holds even if div_ready_i=1 in the same cycle.
- DONE: wb_valid_o=1 for exactly one cycle, with wb_addr_o and wb_data_o valid. Next state is IDLE.
- FLUSH: start low for one cycle so the divider returns to its free state. Next state is IDLE.
- div_start_o is low in IDLE, DONE and FLUSH. This guarantees at least one start-low cycle between consecutive divisions.
- div_annul_o = annul_i while in BUSY, else 0.
- stall_o = (IDLE & req_valid_i & ~annul_i) | BUSY | FLUSH. It is low in DONE.
- Signed overflow (0x80000000 / 0xFFFFFFFF) is not special-cased. The divider yields quotient 0x80000000 and remainder 0.

## Timing
- Request at cycle 0, divide-by-zero path: wb_valid_o at cycle 1.
- Request at cycle 0, divider path:
  - div_start_o rises at cycle 1.
  - The divider takes 35 cycles, so div_ready_i is seen at cycle 36.
  - wb_valid_o fires at cycle 37.
- Total latency is divider latency + 2.
- A new request can be accepted in the cycle after DONE, when the state is back in IDLE.
- wb_* outputs are registered. div_* and stall_o outputs are combinational from state and registers.
- Reset asserted mid-division: returns to IDLE immediately with all outputs 0. The divider is reset by the same n_rst_i.

## Configuration
- DIV_RESULT_REUSE_EN defined: keep the last divider-produced 64-bit result, its rs1, rs2, signed flag and a valid bit.
  - A request whose rs1, rs2 and signed flag match a valid entry takes the divide-by-zero-style one-cycle path (wb_valid_o at cycle 1), with no div_start_o.
  - The entry is written only on BUSY→DONE.
  - The entry is cleared by reset and never updated on annul.
- DIV_RESULT_REUSE_EN undefined: no storage; every nonzero-divisor request uses the divider.

## Test plan
- DIVU 100/7, rd=5 → div_start_o high from cycle 1 until ready; wb_valid_o at cycle 37 with addr 5, data 14. stall_o high cycles 0–36.
- REM 0xFFFFFF9C (−100) / 7 → data 0xFFFFFFFE (−2). Then DIV with the same operands → 0xFFFFFFF2 (−14). With DIV_RESULT_REUSE_EN, the second request completes at cycle 1 with no div_start_o.
- DIV 1234/0 → data 0xFFFFFFFF at cycle 1; div_start_o never asserted. REMU 1234/0 → 1234.
- DIV 0x80000000 / 0xFFFFFFFF → data 0x80000000. REM with the same operands → 0.
- annul_i pulsed at cycle 10 of a DIVU:
  - div_annul_o=1 that cycle, then FLUSH, then IDLE.
  - No wb_valid_o.
  - A following DIVU 9/3 returns 3 with correct latency.
- Back-to-back requests: req_valid_i held high. The second request is accepted the cycle after DONE, with div_start_o low for at least one cycle in between. Both results are correct.
